// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: state encoding,
// error codes and the default frame header.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEF_HEADER = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_if.sv
// Byte-in / payload-out bundle of the frame parser. The parser is the slave;
// the UART receiver plus the application consumer form the master side.
interface uart_frame_if;
    logic       RX_Done_Sig;
    logic [7:0] RX_Data;
    logic       RX_En_Sig;
    logic [7:0] Out_Data;
    logic       Out_Valid;
    logic       Out_Ready;
    logic       Out_Last;
    logic       Err_Sig;
    logic [1:0] Err_Code;
    logic [7:0] Drop_Cnt;

    modport master (
        output RX_Done_Sig, RX_Data, Out_Ready,
        input  RX_En_Sig, Out_Data, Out_Valid, Out_Last, Err_Sig, Err_Code, Drop_Cnt
    );

    modport slave (
        input  RX_Done_Sig, RX_Data, Out_Ready,
        output RX_En_Sig, Out_Data, Out_Valid, Out_Last, Err_Sig, Err_Code, Drop_Cnt
    );
endinterface

// File: rtl/uart_frame_parser_frame_buffer.sv
// Payload store: DEPTH x 8 register file, synchronous write, combinational read.
// Contents need no reset; a frame is always fully written before it is read.
module frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_frame_parser.sv
// Frame delineation (HEADER, LEN, payload, CSUM), checksum/length/timeout
// checking, and valid/ready replay of each good payload.
//
//   state  | meaning
//   IDLE   | hunting for the header byte
//   LEN    | waiting for the length byte
//   DATA   | storing payload bytes into the buffer
//   CSUM   | waiting for the checksum byte
//   OUT    | replaying the payload; receive disabled, stray bytes counted as drops
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] HEADER      = DEF_HEADER,
    parameter int         TIMEOUT_CYC = 104166
) (
    input  logic        CLK,
    input  logic        RSTn,
    uart_frame_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    state_t           state_q;
    logic             rx_done_q, acc_q;
    logic [7:0]       byte_q;
    logic [LEN_W-1:0] len_q, wr_idx_q, rd_idx_q;
    logic [7:0]       sum_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       out_data_q, drop_q;
    logic             out_valid_q, out_last_q, err_q;
    logic [1:0]       err_code_q;

    logic [LEN_W-1:0] rd_next_d;
    logic [7:0]       rd_data;
    logic             buf_we;

    assign buf_we    = acc_q && (state_q == S_DATA);
    // Read address leads the output register so the next byte is ready at handshake.
    assign rd_next_d = (state_q == S_OUT) ? rd_idx_q + 1'b1 : '0;

    frame_buffer #(.DEPTH(MAX_LEN), .AW(IDX_W)) u_buf (
        .CLK     (CLK),
        .we_i    (buf_we),
        .waddr_i (wr_idx_q[IDX_W-1:0]),
        .wdata_i (byte_q),
        .raddr_i (rd_next_d[IDX_W-1:0]),
        .rdata_o (rd_data)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_done_q <= 1'b0;
            acc_q     <= 1'b0;
            byte_q    <= '0;
        end else begin
            rx_done_q <= bus.RX_Done_Sig;
            acc_q     <= bus.RX_Done_Sig & ~rx_done_q;
            if (bus.RX_Done_Sig & ~rx_done_q) byte_q <= bus.RX_Data;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            drop_q      <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (acc_q && byte_q == HEADER) begin
                        state_q <= S_LEN;
                        tmo_q   <= '0;
                    end
                end
                S_LEN, S_DATA, S_CSUM: begin
                    // A byte landing on the expiry cycle takes priority over the timeout.
                    if (acc_q) begin
                        tmo_q <= '0;
                        if (state_q == S_LEN) begin
                            if (byte_q == 8'd0 || byte_q > MAX_LEN_B) begin
                                state_q    <= S_IDLE;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_LEN;
                            end else begin
                                len_q    <= byte_q[LEN_W-1:0];
                                sum_q    <= byte_q;
                                wr_idx_q <= '0;
                                state_q  <= S_DATA;
                            end
                        end else if (state_q == S_DATA) begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                            sum_q    <= sum_q + byte_q;
                            if (wr_idx_q == len_q - 1'b1) state_q <= S_CSUM;
                        end else if (byte_q == sum_q) begin
                            state_q     <= S_OUT;
                            rd_idx_q    <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= rd_data;
                            out_last_q  <= (len_q == LEN_W'(1));
                        end else begin
                            state_q    <= S_IDLE;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q    <= S_IDLE;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (acc_q) drop_q <= sat_inc8(drop_q);
                    if (out_valid_q && bus.Out_Ready) begin
                        if (out_last_q) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            rd_idx_q   <= rd_next_d;
                            out_data_q <= rd_data;
                            out_last_q <= (rd_next_d == len_q - 1'b1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.RX_En_Sig = (state_q != S_OUT);
    assign bus.Out_Data  = out_data_q;
    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_Last  = out_last_q;
    assign bus.Err_Sig   = err_q;
    assign bus.Err_Code  = err_code_q;
    assign bus.Drop_Cnt  = drop_q;
endmodule
